// File: rtl/pmod_da2_driver.sv
// rtl/pmod_da2_driver.sv - Pmod DA2 single-channel serialiser for 8-bit waveform samples
// Widens each accepted sample to a 12-bit code and shifts a 16-bit frame out MSB first.
module pmod_da2_driver #(
  parameter int CLK_DIV    = 2,
  parameter int GAP_CYCLES = 4,
  parameter bit SIGNED_IN  = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] s_data,
  input  logic       s_valid,
  output logic       s_ready,
  output logic       dac_sync,
  output logic       dac_sclk,
  output logic       dac_din,
  output logic       frame_done
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

  state_t           state;
  logic [DIV_W-1:0] div_cnt;
  logic [GAP_W-1:0] gap_cnt;
  logic [3:0]       bit_cnt;
  logic [15:0]      shreg;
  logic [7:0]       u;
  logic [15:0]      frame_in;

  // Replicating the top nibble maps full scale 0xFF onto 0xFFF rather than 0xFF0.
  assign u        = SIGNED_IN ? {~s_data[7], s_data[6:0]} : s_data;
  assign frame_in = {4'b0000, u, u[7:4]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      div_cnt    <= '0;
      gap_cnt    <= '0;
      bit_cnt    <= '0;
      shreg      <= '0;
      s_ready    <= 1'b0;
      dac_sync   <= 1'b1;
      dac_sclk   <= 1'b1;
      dac_din    <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (s_valid && s_ready) begin
            shreg    <= frame_in;
            dac_sync <= 1'b0;
            dac_din  <= frame_in[15];
            bit_cnt  <= 4'd15;
            div_cnt  <= '0;
            s_ready  <= 1'b0;
            state    <= SHIFT;
          end else begin
            s_ready <= 1'b1;
          end
        end
        SHIFT: begin
          if (div_cnt == DIV_LAST) begin
            div_cnt  <= '0;
            dac_sclk <= ~dac_sclk;
            // Data only moves on the rising toggle, a full half-period away from each capture.
            if (!dac_sclk) begin
              if (bit_cnt != 4'd0) begin
                bit_cnt <= bit_cnt - 4'd1;
                dac_din <= shreg[bit_cnt - 4'd1];
              end else begin
                dac_sync   <= 1'b1;
                dac_din    <= 1'b0;
                gap_cnt    <= '0;
                frame_done <= 1'b1;
                state      <= GAP;
              end
            end
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        GAP: begin
          if (gap_cnt == GAP_LAST) begin
            s_ready <= 1'b1;
            state   <= IDLE;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pmod_da2_driver.sv
// tb/tb_pmod_da2_driver.sv - directed self-checking bench for pmod_da2_driver
module tb_pmod_da2_driver;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] valid, ready, sync, sclk, din, fdone;
  logic [7:0] data [3];

  always #5 clk = ~clk;

  pmod_da2_driver #(.CLK_DIV(2), .GAP_CYCLES(4), .SIGNED_IN(1'b1)) u_dut0 (
    .clk(clk), .rst(rst), .s_data(data[0]), .s_valid(valid[0]), .s_ready(ready[0]),
    .dac_sync(sync[0]), .dac_sclk(sclk[0]), .dac_din(din[0]), .frame_done(fdone[0]));
  pmod_da2_driver #(.CLK_DIV(2), .GAP_CYCLES(4), .SIGNED_IN(1'b0)) u_dut1 (
    .clk(clk), .rst(rst), .s_data(data[1]), .s_valid(valid[1]), .s_ready(ready[1]),
    .dac_sync(sync[1]), .dac_sclk(sclk[1]), .dac_din(din[1]), .frame_done(fdone[1]));
  pmod_da2_driver #(.CLK_DIV(1), .GAP_CYCLES(1), .SIGNED_IN(1'b1)) u_dut2 (
    .clk(clk), .rst(rst), .s_data(data[2]), .s_valid(valid[2]), .s_ready(ready[2]),
    .dac_sync(sync[2]), .dac_sclk(sclk[2]), .dac_din(din[2]), .frame_done(fdone[2]));

  int checks = 0;
  int failures = 0;
  int ncyc = 0;

  logic [2:0] prev_sclk, prev_sync, prev_ready;
  logic [15:0] sh [3];
  logic [15:0] frame_word [3];
  logic [7:0]  acc_data [3];
  logic [7:0]  frame_data [3];
  int falls [3], low_cnt [3], frames [3], frame_falls [3], frame_low [3];
  int fdone_cnt [3], sync_bad [3], fall_total [3], acc_time [3], spacing [3];

  // Frame monitor: captures DIN on every SCLK fall, closes a frame on SYNC rising.
  always @(negedge clk) begin
    ncyc++;
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        prev_sclk[i] = 1'b1;
        prev_sync[i] = 1'b1;
        prev_ready[i] = 1'b0;
        falls[i] = 0;
        low_cnt[i] = 0;
      end else begin
        if (prev_sclk[i] && !sclk[i]) begin
          sh[i] = {sh[i][14:0], din[i]};
          falls[i]++;
          fall_total[i]++;
          if (sync[i]) sync_bad[i]++;
        end
        if (!sync[i]) low_cnt[i]++;
        if (!prev_sync[i] && sync[i]) begin
          frame_word[i] = sh[i];
          frame_falls[i] = falls[i];
          frame_low[i] = low_cnt[i];
          frame_data[i] = acc_data[i];
          frames[i]++;
          falls[i] = 0;
          low_cnt[i] = 0;
        end
        if (fdone[i]) fdone_cnt[i]++;
        if (prev_ready[i] && !ready[i]) begin
          spacing[i] = ncyc - acc_time[i];
          acc_time[i] = ncyc;
          acc_data[i] = data[i];
        end
        prev_sclk[i] = sclk[i];
        prev_sync[i] = sync[i];
        prev_ready[i] = ready[i];
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] conv(input logic [7:0] d, input bit signed_in);
    logic [7:0] u;
    u = signed_in ? (d ^ 8'h80) : d;
    return {4'h0, u, u[7:4]};
  endfunction

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_frames(input int i, input int target, input int budget);
    int n;
    n = 0;
    while (frames[i] < target && n < budget) begin
      tick();
      n++;
    end
    check("frame_timeout", 32'(frames[i] >= target), 32'd1);
  endtask

  task automatic send(input int i, input logic [7:0] d);
    int n;
    int target;
    n = 0;
    while (!ready[i] && n < 200) begin
      tick();
      n++;
    end
    target = frames[i] + 1;
    data[i] = d;
    valid[i] = 1'b1;
    tick();
    valid[i] = 1'b0;
    wait_frames(i, target, 200);
  endtask

  task automatic send_check(input int i, input logic [7:0] d, input logic [15:0] exp);
    send(i, d);
    check("frame_word", 32'(frame_word[i]), 32'(exp));
    check("frame_falls", frame_falls[i], 16);
    check("frame_done_cnt", fdone_cnt[i], frames[i]);
  endtask

  initial begin
    int bad, base, ftot;
    for (int i = 0; i < 3; i++) begin
      sh[i] = '0; frame_word[i] = '0; acc_data[i] = '0; frame_data[i] = '0;
      falls[i] = 0; low_cnt[i] = 0; frames[i] = 0; frame_falls[i] = 0; frame_low[i] = 0;
      fdone_cnt[i] = 0; sync_bad[i] = 0; fall_total[i] = 0; acc_time[i] = 0; spacing[i] = 0;
      data[i] = 8'h00;
    end
    valid = '0;
    rst = 1'b1;
    repeat (3) tick();
    check("rst_ready", 32'(ready[0]), 0);
    check("rst_sync", 32'(sync[0]), 1);
    check("rst_sclk", 32'(sclk[0]), 1);
    check("rst_din", 32'(din[0]), 0);
    check("rst_fdone", 32'(fdone[0]), 0);
    rst = 1'b0;
    check("ready_before_edge", 32'(ready[0]), 0);
    tick();
    check("ready_after_rst", 32'(ready[0]), 1);

    send_check(0, 8'h00, 16'h0808);
    check("shift_len_div2", frame_low[0], 64);
    send_check(0, 8'h7F, 16'h0FFF);
    send_check(0, 8'h80, 16'h0000);
    send_check(0, 8'h5A, 16'h0DAD);
    send_check(1, 8'h80, 16'h0808);
    send_check(1, 8'h3C, 16'h03C3);
    send_check(2, 8'hA5, 16'h0252);
    check("shift_len_div1", frame_low[2], 32);

    // ROM-style source: valid held, data changes every cycle.
    base = frames[0];
    valid[0] = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      bad = 0;
      while (frames[0] < base + k && bad < 300) begin
        data[0] = 8'(ncyc) ^ 8'h35;
        tick();
        bad++;
      end
      if (k == 3) valid[0] = 1'b0;
      check("rom_timeout", 32'(frames[0] >= base + k), 1);
      check("rom_word", 32'(frame_word[0]), 32'(conv(frame_data[0], 1'b1)));
      if (k > 1) check("rom_spacing", spacing[0], 69);
    end

    base = frames[2];
    valid[2] = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      bad = 0;
      while (frames[2] < base + k && bad < 200) begin
        data[2] = 8'(ncyc * 7);
        tick();
        bad++;
      end
      if (k == 3) valid[2] = 1'b0;
      check("div1_timeout", 32'(frames[2] >= base + k), 1);
      check("div1_word", 32'(frame_word[2]), 32'(conv(frame_data[2], 1'b1)));
      check("div1_falls", frame_falls[2], 16);
      if (k > 1) check("div1_spacing", spacing[2], 34);
    end

    // Idle with s_valid low: no activity, data ignored.
    repeat (10) tick();
    base = frames[0];
    ftot = fall_total[0];
    bad = 0;
    for (int k = 0; k < 100; k++) begin
      data[0] = 8'($urandom);
      tick();
      if (!sync[0] || !sclk[0] || !ready[0]) bad++;
    end
    check("idle_quiet", bad, 0);
    check("idle_no_sclk", fall_total[0], ftot);
    check("idle_no_frames", frames[0], base);
    send(0, 8'h11);
    repeat (150) tick();
    check("pulse_one_frame", frames[0], base + 1);
    check("pulse_word", 32'(frame_word[0]), 32'h0919);

    // Reset in the middle of a frame.
    base = frames[0];
    data[0] = 8'h40;
    valid[0] = 1'b1;
    tick();
    valid[0] = 1'b0;
    repeat (20) tick();
    #2 rst = 1'b1;
    #1;
    check("midrst_sync", 32'(sync[0]), 1);
    check("midrst_sclk", 32'(sclk[0]), 1);
    check("midrst_din", 32'(din[0]), 0);
    check("midrst_ready", 32'(ready[0]), 0);
    tick();
    rst = 1'b0;
    tick();
    check("midrst_ready_rel", 32'(ready[0]), 1);
    check("midrst_no_frame", frames[0], base);
    send_check(0, 8'h7F, 16'h0FFF);

    for (int i = 0; i < 3; i++) check("sync_low_at_falls", sync_bad[i], 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
